// File: rtl/alu_exec_unit.sv
// Execute stage: opcode decode, ALU, shift-add multiplier, register file and
// result/flag registers behind valid/ready handshakes on both sides.
// Results and flags are written back at the edge that enters DONE, so an
// instruction accepted while leaving DONE already sees the new values.
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             imm_en,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    rd_out,
    output logic             carry,
    output logic             zero,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   result_q, result_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic               wr_en;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     ext;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign dbg_data  = regs_q[dbg_addr];

    assign op_a = regs_q[rs1];
    assign op_b = imm_en ? imm : regs_q[rs2];

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle ALU result and carry for the instruction being accepted.
    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                ext     = {1'b0, op_a} - {1'b0, op_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                alu_c   = op_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a[WIDTH-1:1]};
                alu_c   = op_a[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // Next-state, multiplier datapath and writeback decisions.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    rd_d = rd;
                    if (opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, op_a};
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = CNT_LAST;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_c;
                        zero_d   = (alu_res == '0);
                        wr_en    = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    wr_en    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control, result and multiplier registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            rd_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Register file; the completing result lands in reg[rd] at the DONE-entry edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_d] <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=8, NREGS=4): directed scenarios plus random
// back-to-back traffic checked against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 8;
    localparam longint MOD = 64'd1 << W;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] opcode = 3'd0;
    logic [1:0] rd = 2'd0, rs1 = 2'd0, rs2 = 2'd0;
    logic       imm_en = 1'b0;
    logic [7:0] imm = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [1:0] rd_out;
    logic       carry, zero;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] m_regs [4];

    alu_exec_unit #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm_en(imm_en), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_out(rd_out),
        .carry(carry), .zero(zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the architectural register file.
    task automatic model_step(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                              input logic [1:0] s2, input logic ie, input logic [7:0] im,
                              output logic [7:0] er, output logic ec, output logic ez);
        longint a, b, r;
        a = longint'(m_regs[s1]);
        b = ie ? longint'(im) : longint'(m_regs[s2]);
        r = 0;
        ec = 1'b0;
        case (op)
            3'd0: begin r = a + b;        ec = (r >= MOD); end
            3'd1: begin r = a - b + MOD;  ec = (a < b);    end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a * 2;        ec = (r >= MOD); end
            3'd6: begin r = a / 2;        ec = (a % 2) == 1; end
            default: begin r = a * b;     ec = (r >= MOD); end
        endcase
        er = 8'(r % MOD);
        ez = (er == 8'd0);
        m_regs[d] = er;
    endtask

    // Offers one instruction, waits for its acceptance and its result (bounded).
    task automatic run_instr(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                             input logic [1:0] s2, input logic ie, input logic [7:0] im,
                             output logic [7:0] er, output logic ec, output logic ez,
                             output int lat, output bit to);
        int w;
        to = 1'b0;
        lat = 0;
        er = 8'd0; ec = 1'b0; ez = 1'b0;
        @(negedge clk);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; imm_en = ie; imm = im;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        model_step(op, d, s1, s2, ie, im, er, ec, ez);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            n_assert++;
            if (dbg_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d: dbg_data=%h expected 00", i, dbg_data);
            end
            m_regs[i] = 8'h00;
        end
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || carry !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b carry=%b zero=%b expected 0 1 0 0",
                     out_valid, in_ready, carry, zero);
        end
    endtask

    task automatic test_add();
        logic [7:0] er; logic ec, ez; int lat; bit to;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'hF0, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== 8'hF0 || carry !== 1'b0 || lat != 0) begin
            n_fail++;
            $display("FAIL add_load: result=%h carry=%b lat=%0d timeout=%b expected F0 0 0 0",
                     result, carry, lat, to);
        end
        run_instr(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h20, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== 8'h10 || carry !== 1'b1 || zero !== 1'b0 || rd_out !== 2'd2) begin
            n_fail++;
            $display("FAIL add_carry: result=%h carry=%b zero=%b rd_out=%0d timeout=%b expected 10 1 0 2",
                     result, carry, zero, rd_out, to);
        end
        dbg_addr = 2'd2;
        @(posedge clk); #1;
        n_assert++;
        if (dbg_data !== 8'h10) begin
            n_fail++;
            $display("FAIL add_dbg: dbg_data=%h expected 10", dbg_data);
        end
    endtask

    task automatic test_sub();
        logic [7:0] er; logic ec, ez; int lat; bit to;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, er, ec, ez, lat, to);
        run_instr(3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 8'h05, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_equal: result=%h zero=%b carry=%b timeout=%b expected 00 1 0",
                     result, zero, carry, to);
        end
        run_instr(3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 8'h06, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: result=%h carry=%b zero=%b timeout=%b expected FF 1 0",
                     result, carry, zero, to);
        end
    endtask

    task automatic test_mul();
        logic [7:0] er; logic ec, ez; int lat; bit to;
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F, er, ec, ez, lat, to);
        run_instr(3'd7, 2'd2, 2'd1, 2'd0, 1'b1, 8'h11, er, ec, ez, lat, to);
        n_assert++;
        if (to || lat != W) begin
            n_fail++;
            $display("FAIL mul_latency: edges after accept=%0d timeout=%b expected %0d", lat, to, W);
        end
        n_assert++;
        if (result !== 8'hFF || carry !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_0f_11: result=%h carry=%b zero=%b expected FF 0 0", result, carry, zero);
        end
        run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h20, er, ec, ez, lat, to);
        run_instr(3'd7, 2'd3, 2'd1, 2'd0, 1'b1, 8'h10, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_overflow: result=%h carry=%b zero=%b timeout=%b expected 00 1 1",
                     result, carry, zero, to);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] er, er2; logic ec, ez, ec2, ez2; int lat; bit to;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_instr(3'd4, 2'd3, 2'd1, 2'd0, 1'b1, 8'h5A, er, ec, ez, lat, to);
        n_assert++;
        if (to || result !== er || carry !== ec || zero !== ez) begin
            n_fail++;
            $display("FAIL bp_first: result=%h carry=%b zero=%b expected %h %b %b", result, carry, zero, er, ec, ez);
        end
        @(negedge clk);
        opcode = 3'd0; rd = 2'd0; rs1 = 2'd3; rs2 = 2'd0; imm_en = 1'b1; imm = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_assert++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || carry !== ec || zero !== ez) begin
                n_fail++;
                $display("FAIL bp_stall%0d: out_valid=%b in_ready=%b result=%h carry=%b zero=%b expected 1 0 %h %b %b",
                         i, out_valid, in_ready, result, carry, zero, er, ec, ez);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b expected 1", in_ready);
        end
        model_step(3'd0, 2'd0, 2'd3, 2'd0, 1'b1, 8'h01, er2, ec2, ez2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_assert++;
        if (out_valid !== 1'b1 || result !== er2 || rd_out !== 2'd0 || carry !== ec2 || zero !== ez2) begin
            n_fail++;
            $display("FAIL bp_same_cycle: out_valid=%b result=%h rd_out=%0d carry=%b zero=%b expected 1 %h 0 %b %b",
                     out_valid, result, rd_out, carry, zero, er2, ec2, ez2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] er; logic ec, ez; int lat; bit to;
        logic [2:0] op; logic [1:0] d, s1, s2; logic ie; logic [7:0] im;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            d  = 2'($urandom_range(0, 3));
            s1 = 2'($urandom_range(0, 3));
            s2 = 2'($urandom_range(0, 3));
            ie = 1'($urandom_range(0, 1));
            im = 8'($urandom_range(0, 255));
            dbg_addr = d;
            run_instr(op, d, s1, s2, ie, im, er, ec, ez, lat, to);
            n_assert++;
            if (to || lat != ((op == 3'd7) ? W : 0)) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: op=%0d lat=%0d timeout=%b", n, op, lat, to);
            end
            n_assert++;
            if (result !== er || carry !== ec || zero !== ez || rd_out !== d || dbg_data !== er) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: op=%0d result=%h carry=%b zero=%b rd_out=%0d dbg=%h expected %h %b %b %0d",
                         n, op, result, carry, zero, rd_out, dbg_data, er, ec, ez, d);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] er; logic ec, ez; int lat; bit to;
        int ov_seen;
        @(negedge clk);
        opcode = 3'd7; rd = 2'd3; rs1 = 2'd1; rs2 = 2'd2; imm_en = 1'b1; imm = 8'h37;
        in_valid = 1'b1;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmul_accept: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        dbg_addr = 2'd3;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || dbg_data !== 8'h00 || carry !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmul_abort: out_valid=%b reg3=%h carry=%b zero=%b in_ready=%b expected 0 00 0 0 1",
                     out_valid, dbg_data, carry, zero, in_ready);
        end
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        n_assert++;
        if (ov_seen != 0 || dbg_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmul_no_resume: out_valid cycles=%0d reg3=%h expected 0 00", ov_seen, dbg_data);
        end
        run_instr(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h33, er, ec, ez, lat, to);
        n_assert++;
        if (to || lat != 0 || result !== 8'h33 || carry !== 1'b0 || zero !== 1'b0 || rd_out !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmul_next_add: result=%h carry=%b zero=%b rd_out=%0d lat=%0d timeout=%b expected 33 0 0 2 0",
                     result, carry, zero, rd_out, lat, to);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute stage for the CPU datapath. It merges opcode decode, ALU and result register into one handshaked unit with an internal register file, persistent carry/zero flags and a multi-cycle shift-add multiplier. Instructions enter through a valid/ready port and results leave through a valid/ready port. Every result is written back to the register file on completion.

## Interface
- WIDTH, 8, datapath width in bits (>=4)
- NREGS, 4, register-file depth (power of two, >=2); AW = clog2(NREGS)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept an instruction this cycle
- opcode  in  3  operation select
- rd, rs1, rs2  in  AW each  destination and source register indices
- imm_en  in  1  1: operand B = imm, 0: operand B = reg[rs2]
- imm  in  WIDTH  immediate operand
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  completed result
- rd_out  out  AW  destination index of the completed result
- carry, zero  out  1 each  flag register contents
- dbg_addr  in  AW  debug read index
- dbg_data  out  WIDTH  combinational reg[dbg_addr]

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL A by 1, 110 SHR A by 1 (logical), 111 MUL (low WIDTH bits of A*B).
- Carry rules:
  - ADD: carry = bit WIDTH of A+B.
  - SUB: carry = 1 when A<B unsigned (borrow); result = A-B mod 2^WIDTH.
  - SHL: carry = A[WIDTH-1]. SHR: carry = A[0].
  - AND/OR/XOR: carry = 0.
  - MUL: carry = 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
- Zero flag: zero = (result == 0).
- Operands A=reg[rs1] and B (reg[rs2] or imm) are sampled at the accepting edge.
- States:
  - IDLE: in_ready=1; on accept, go to DONE for opcodes 000–110 and to MUL for 111.
  - MUL: in_ready=0. Runs a WIDTH-iteration shift-add, one multiplier bit per cycle, with a 2*WIDTH accumulator; after the last iteration, go to DONE.
  - DONE: out_valid=1; result, rd_out and flags are held stable. On out_ready, go to IDLE, or accept a new instruction in the same cycle if in_valid (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Writeback:
  - reg[rd] and the flags are updated at the edge entering DONE.
  - Flags change only at completion and persist until the next completion.
  - An instruction accepted in DONE therefore reads already-updated registers; no hazard logic is needed.
- All registers are ordinary and writable, including reg[0].
- dbg_data reflects writes from the edge after the write.

## Timing
- Reset (rst low, async):
  - State IDLE; all registers, result, rd_out, carry and zero cleared to 0.
  - out_valid=0; in_ready=1 once rst is high.
- Single-cycle ops: accept at edge N, out_valid=1 in cycle N+1.
- MUL: accept at edge N, out_valid=1 in cycle N+WIDTH+1.
- Back-to-back single-cycle ops with out_ready held 1 give one result per cycle after the first.
- Holding out_ready=0 stalls the unit in DONE indefinitely, with outputs stable and in_ready=0.
- in_valid while in_ready=0 is ignored; the instruction is not captured.
- Reset mid-MUL or mid-DONE:
  - Aborts the operation with no writeback.
  - Registers and flags are cleared per the reset values.
- rd equal to rs1 or rs2 is legal; sources are read before the write.

## Test plan (WIDTH=8, NREGS=4)
- Reset, then probe dbg_addr 0..3 -> dbg_data=0 for every register; out_valid=0, in_ready=1, carry=0, zero=0.
- ADD imm 0xF0 into r1 (r1=0xF0), then ADD r1+imm 0x20 into r2 -> result 0x10, carry=1, zero=0, and dbg reg2 reads 0x10 one cycle later.
- SUB: r1=0x05, imm 0x05 -> result 0x00, zero=1, carry=0; then r1=0x05, imm 0x06 -> result 0xFF, carry=1.
- MUL: r1=0x0F, imm 0x11 -> out_valid exactly 9 cycles after accept, result 0xFF, carry=0; 0x20 * 0x10 -> result 0x00, carry=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> new instruction accepted in the same cycle.
- Assert rst at MUL cycle 4 -> out_valid stays 0, reg[rd] stays 0, the unit returns to IDLE, and the next ADD completes normally.
